// File: rtl/rhombus_phase_gen.sv
// Programmable phase counter feeding the rhomboid shaper: prescaled phase ramp with
// valid/ready reloadable rate and graceful stop. Optional build macro: RHOMBUS_PG_SNAP_EN.
module rhombus_phase_gen #(
  parameter int DIV_W = 16,
  parameter int PH_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [PH_W-1:0]  cfg_step,
  output logic [PH_W-1:0]  cout,
  output logic             res,
  output logic             wrap,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_a, div_s, pcnt;
  logic [PH_W-1:0]  step_a, step_s, step_eff, phase_nx;
  logic [PH_W:0]    sum;
  logic             pend, tick, carry, wrap_now, hs, to_idle, idle_load;

  always_comb begin
    step_eff = (step_a == '0) ? PH_W'(1) : step_a;
    sum      = {1'b0, cout} + {1'b0, step_eff};
    carry    = sum[PH_W];
    tick     = (state != IDLE) && (pcnt == div_a);
    wrap_now = tick & carry;
    hs       = cfg_valid & ~pend;
`ifdef RHOMBUS_PG_SNAP_EN
    phase_nx = carry ? '0 : sum[PH_W-1:0];
`else
    phase_nx = sum[PH_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !stop) state_nx = RUN;
      RUN:     if (stop) state_nx = DRAIN;
      DRAIN: begin
        if (start && !stop) state_nx = RUN;
        else if (wrap_now)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    running   = (state != IDLE);
    cfg_ready = ~pend;
  end

  // Final wrap of a drain behaves like IDLE for both the phase and a coincident config load.
  assign to_idle   = (state == DRAIN) && (state_nx == IDLE);
  assign idle_load = (state == IDLE) || to_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      cout   <= '0;
      res    <= 1'b0;
      wrap   <= 1'b0;
      pcnt   <= '0;
      div_a  <= '0;
      step_a <= PH_W'(1);
      div_s  <= '0;
      step_s <= '0;
      pend   <= 1'b0;
    end else begin
      wrap <= wrap_now;

      if (idle_load) begin
        pcnt <= '0;
        cout <= '0;
        res  <= 1'b0;
      end else if (tick) begin
        pcnt <= '0;
        cout <= phase_nx;
        res  <= res ^ carry;
      end else begin
        pcnt <= pcnt + DIV_W'(1);
      end

      // hs requires ~pend, so a commit and a new handshake never coincide.
      if (wrap_now && pend) begin
        div_a  <= div_s;
        step_a <= step_s;
        pend   <= 1'b0;
      end else if (hs) begin
        if (idle_load) begin
          div_a  <= cfg_div;
          step_a <= cfg_step;
        end else begin
          div_s  <= cfg_div;
          step_s <= cfg_step;
          pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhombus_phase_gen.sv
// Scoreboard bench for rhombus_phase_gen: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares.
module tb_rhombus_phase_gen;

  localparam int DIV_W = 16;
  localparam int PH_W  = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, cfg_valid;
  logic             cfg_ready, res, wrap, running;
  logic [DIV_W-1:0] cfg_div;
  logic [PH_W-1:0]  cfg_step, cout;

  typedef struct {
    string          tag;
    logic [PH_W-1:0] c;
    logic           r, w, run, rdy;
  } exp_t;

  exp_t q[$];
  int   vectors   = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rhombus_phase_gen #(.DIV_W(DIV_W), .PH_W(PH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_step(cfg_step),
    .cout(cout), .res(res), .wrap(wrap), .running(running)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (cout !== e.c || res !== e.r || wrap !== e.w || running !== e.run || cfg_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s: got cout=%0d res=%b wrap=%b running=%b cfg_ready=%b, want cout=%0d res=%b wrap=%b running=%b cfg_ready=%b",
                 e.tag, cout, res, wrap, running, cfg_ready, e.c, e.r, e.w, e.run, e.rdy);
      end
    end
  end

  // One clock edge with current inputs, then queue the outputs expected after that edge.
  task automatic cyc(input string tag, input int c, input logic r, input logic w,
                     input logic run, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag; e.c = PH_W'(c); e.r = r; e.w = w; e.run = run; e.rdy = rdy;
    q.push_back(e);
  endtask

  // Reset, optionally load config in IDLE, then start; phase sits at 0 after the start edge.
  task automatic run_start(input logic do_cfg, input int div, input int step);
    rst = 1'b1;
    cyc("reset", 0, 0, 0, 0, 1);
    rst = 1'b0;
    if (do_cfg) begin
      cfg_valid = 1'b1; cfg_div = DIV_W'(div); cfg_step = PH_W'(step);
      cyc("cfg_idle", 0, 0, 0, 0, 1);
      cfg_valid = 1'b0;
    end
    start = 1'b1;
    cyc("start", 0, 0, 0, 1, 1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; cfg_step = '0;

    // Unit-step sweep: 512 ticks, res toggles at each wrap
    run_start(1'b1, 0, 1);
    for (int t = 1; t <= 512; t++)
      cyc("sweep1", t % 256, (t >= 256 && t < 512), (t % 256 == 0), 1, 1);

    // Runtime reload of step 2 offered at cout=10
    for (int t = 1; t <= 10; t++) cyc("pre_cfg", t, 0, 0, 1, 1);
    cfg_valid = 1'b1; cfg_div = '0; cfg_step = 8'd2;
    cyc("cfg_accept", 11, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    for (int c = 12; c <= 255; c++) cyc("pend_step1", c, 0, 0, 1, 0);
    cyc("commit_wrap", 0, 1, 1, 1, 1);
    for (int k = 1; k <= 127; k++) cyc("step2", 2 * k, 1, 0, 1, 1);
    cyc("step2_wrap", 0, 0, 1, 1, 1);

    // Prescaler div=3, step 64
    run_start(1'b1, 3, 64);
    for (int k = 1; k <= 8; k++) begin
      for (int h = 0; h < 3; h++)
        cyc("div3_hold", (64 * (k - 1)) % 256, ((k - 1) / 4) % 2, 0, 1, 1);
      cyc("div3_tick", (64 * k) % 256, (k / 4) % 2, (k % 4 == 0), 1, 1);
    end

    // Graceful stop at cout=100
    run_start(1'b1, 0, 1);
    for (int t = 1; t <= 100; t++) cyc("to_stop", t, 0, 0, 1, 1);
    stop = 1'b1;
    cyc("stop_req", 101, 0, 0, 1, 1);
    stop = 1'b0;
    for (int c = 102; c <= 255; c++) cyc("drain", c, 0, 0, 1, 1);
    cyc("drain_end", 0, 0, 1, 0, 1);
    cyc("idle_after", 0, 0, 0, 0, 1);
    cyc("idle_after", 0, 0, 0, 0, 1);

    // Stop cancelled by start at cout=200
    start = 1'b1;
    cyc("restart", 0, 0, 0, 1, 1);
    start = 1'b0;
    for (int t = 1; t <= 100; t++) cyc("to_stop2", t, 0, 0, 1, 1);
    stop = 1'b1;
    cyc("stop_req2", 101, 0, 0, 1, 1);
    stop = 1'b0;
    for (int c = 102; c <= 200; c++) cyc("drain2", c, 0, 0, 1, 1);
    start = 1'b1;
    cyc("cancel", 201, 0, 0, 1, 1);
    start = 1'b0;
    for (int c = 202; c <= 255; c++) cyc("rerun", c, 0, 0, 1, 1);
    cyc("rerun_wrap", 0, 1, 1, 1, 1);
    cyc("rerun_go", 1, 1, 0, 1, 1);
    cyc("rerun_go", 2, 1, 0, 1, 1);

    // Non-dividing step 100: remainder kept or snapped
    run_start(1'b1, 0, 100);
    cyc("s100", 100, 0, 0, 1, 1);
    cyc("s100", 200, 0, 0, 1, 1);
`ifdef RHOMBUS_PG_SNAP_EN
    cyc("s100_wrap", 0, 1, 1, 1, 1);
    cyc("s100", 100, 1, 0, 1, 1);
    cyc("s100", 200, 1, 0, 1, 1);
`else
    cyc("s100_wrap", 44, 1, 1, 1, 1);
    cyc("s100", 144, 1, 0, 1, 1);
    cyc("s100", 244, 1, 0, 1, 1);
`endif

    // Reset mid-sweep with a pending config: defaults apply after restart
    run_start(1'b1, 0, 4);
    for (int k = 1; k <= 5; k++) cyc("step4", 4 * k, 0, 0, 1, 1);
    cfg_valid = 1'b1; cfg_div = DIV_W'(5); cfg_step = 8'd8;
    cyc("pend_cfg", 24, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    cyc("pend_hold", 28, 0, 0, 1, 0);
    run_start(1'b0, 0, 0);
    for (int t = 1; t <= 3; t++) cyc("post_rst", t, 0, 0, 1, 1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rhombus_phase_gen.md
# rhombus_phase_gen

Programmable phase counter that drives the rhomboid waveform shaper directly downstream. It produces the 8-bit phase `cout` and the half-select `res`, which toggles on every phase wrap. Sweep rate comes from a prescaler and a phase step, both reloadable at run time through a valid/ready config port. A stop request lets the current sweep finish so the shaper never sees a truncated cycle.

## Interface
- `DIV_W`, 16: prescaler width.
- `PH_W`, 8: phase width; must equal the shaper's `cout` width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level/pulse; request to run.
- `stop`  in  1  level/pulse; request graceful stop at the next wrap.
- `cfg_valid`  in  1  new config offered.
- `cfg_ready`  out  1  config shadow empty; can accept.
- `cfg_div`  in  DIV_W  prescaler terminal count; tick every `cfg_div+1` cycles.
- `cfg_step`  in  PH_W  phase increment per tick; 0 is treated as 1.
- `cout`  out  PH_W  phase to shaper.
- `res`  out  1  half-select to shaper.
- `wrap`  out  1  one-cycle pulse on phase overflow.
- `running`  out  1  high in RUN and DRAIN.

## Operation
- Registers: active `div_a`/`step_a`; shadow `div_s`/`step_s` plus `pend` flag; prescaler `pcnt`.
- `cfg_ready = ~pend`. A handshake is `cfg_valid & cfg_ready`.
  - In IDLE, the handshake loads active registers directly; `pend` stays 0.
  - In RUN/DRAIN, it loads the shadow and sets `pend`.
- Shadow commit: on the cycle a wrap occurs, copy shadow → active and clear `pend`. If a new handshake coincides with a wrap in RUN, it lands in the shadow.
- Tick: `pcnt == div_a`. On tick, `pcnt <= 0`; otherwise `pcnt <= pcnt+1`.
- On tick, `{carry, cout} <= cout + step_eff`, where `step_eff = (step_a==0) ? 1 : step_a`. Arithmetic is PH_W+1 bits and the remainder is kept modulo 2^PH_W.
- `carry = 1` means a wrap: `res <= ~res` and `wrap <= 1` on the same edge.
- FSM:
  - IDLE: `cout`, `pcnt` and `res` are held at 0. `start & ~stop` → RUN with `pcnt = 0`.
  - RUN: `stop` → DRAIN. A wrap in RUN stays in RUN.
  - DRAIN: counts as RUN.
    - `start & ~stop` → RUN (stop cancelled).
    - A wrap in DRAIN → IDLE. On that edge, `cout <= 0`, `res <= 0`, `pcnt <= 0`, and the pending shadow is committed.
- Simultaneous `start` and `stop`: stop wins. In IDLE the block stays IDLE.

## Timing
- Reset values:
  - Outputs: `cout = 0`, `res = 0`, `wrap = 0`, `running = 0`, `cfg_ready = 1`.
  - Internal: `div_a = 0`, `step_a = 1`, `pend = 0`, `pcnt = 0`, state IDLE.
- `rst` overrides everything, including mid-sweep and a pending config (the shadow is discarded).
- `start` sampled at edge N → `running = 1` after edge N. The first `cout` update is at edge N+1+`div_a`.
- With `div_a = 0`, `cout` advances every cycle. Full sweep period = 2^PH_W / step_eff ticks when the step divides 2^PH_W.
- `wrap` is high exactly one cycle, aligned with the updated `cout`/`res`.
- Config accepted in IDLE takes effect from the first tick after start.
- Config accepted while running takes effect on the first tick after the next wrap.
- `cfg_ready` falls the cycle after acceptance while running. It rises the cycle after the commit.
- All outputs are registered; there are no combinational paths from inputs to `cout`/`res`/`wrap`.

## Configuration
- `RHOMBUS_PG_SNAP_EN`
  - Defined: on every wrap, `cout` snaps to 0 and the remainder is discarded. The sweep always restarts at phase 0, so shaper symmetry is exact for any step.
  - Undefined: the remainder is kept (`cout = (cout+step_eff) mod 2^PH_W`), giving phase-continuous frequency for non-power-of-two steps.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then `cfg_div = 0`, `cfg_step = 1`, then `start` pulse. Required:
  - `cout` is 0,1,2,…,255 on consecutive cycles.
  - `wrap` pulses when `cout` returns to 0, and `res` goes 0→1.
  - After 512 ticks, `res` is back to 0.
- `cfg_div = 3`, `cfg_step = 64`, start. Required: `cout` changes every 4 cycles: 64,128,192,0 (wrap),64,…
- Running with `step = 1`, offer `cfg_step = 2` at `cout = 10`. Required:
  - `cfg_ready` drops.
  - `cout` keeps stepping by 1 until the wrap, then steps by 2.
  - `cfg_ready` returns 1 a cycle after the wrap.
- `stop` at `cout = 100` (`step = 1`, `div = 0`). Required:
  - `running` stays 1 through `cout = 255`.
  - At the wrap the FSM enters IDLE, `cout = 0`, `res = 0`, `running = 0`.
  - Repeat with `start` re-asserted at `cout = 200`: the block stays in RUN.
- `step = 100`, `div = 0`, sequence 0,100,200 then wrap. Required: next value is 44 without `RHOMBUS_PG_SNAP_EN` and 0 with it.
- Assert `rst` mid-sweep with a config pending. Required: all reset values on the next edge, and after a restart the old (pre-pending) config is not used.
